proj_fm_stream_ram: RTL
=======================

# proj_fm_stream_ram

Parametrised successor to the projection feature-map RAM in the MinHash datapath. It holds one feature-map slice and keeps independent auto-incrementing write and read pointers. It provides valid/ready write flow control, an occupancy count with full and empty flags, and a random-access mode for host debug and preload. It sits between the projection stage, which writes the slice, and the hash-signature stage, which drains it.

## Interface
- ENTRIES, 8, number of words; any value ≥ 2, not limited to powers of two.
- DATA_BITS, 8, word width.
- ADDR_BITS, $clog2(ENTRIES), derived; not overridden.
- CNT_BITS, $clog2(ENTRIES+1), derived; not overridden.

Ports:
- in_clk  input  1  clock, all logic on the rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_mode  input  1  0 = stream (pointer) mode, 1 = random-access mode.
- in_clr  input  1  synchronous clear of pointers and count.
- in_wr_valid  input  1  write request.
- out_wr_ready  output  1  write accepted when high with in_wr_valid.
- in_wdata  input  DATA_BITS  write data.
- in_addr  input  ADDR_BITS  address, used only in random-access mode.
- in_rd_req  input  1  read request.
- out_rd_valid  output  1  out_rdata is valid this cycle.
- out_rdata  output  DATA_BITS  registered read data.
- out_count  output  CNT_BITS  words held, stream mode.
- out_full  output  1  out_count == ENTRIES.
- out_empty  output  1  out_count == 0.
- out_wrap  output  1  one-cycle pulse when the write pointer wraps.
- out_parity_err  output  1  parity mismatch on the read returned this cycle (PROJ_FM_RAM_PARITY_EN only).

## Operation
- Reset values:
  - waddr, raddr and count are 0.
  - out_rdata is 0, out_rd_valid is 0 and out_wrap is 0.
  - out_empty is 1, out_full is 0 and out_wr_ready is 1.
  - out_parity_err is 0.
  - Memory contents are not reset.
- Stream mode (in_mode = 0):
  - out_wr_ready is !out_full.
  - Write fire is in_wr_valid && out_wr_ready. It writes mem[waddr] and advances waddr.
  - Read fire is in_rd_req && !out_empty. It reads mem[raddr] and advances raddr.
  - A read request while empty is dropped. out_rd_valid stays 0 for that request.
  - Both pointers wrap from ENTRIES-1 to 0. out_wrap pulses in the cycle after a write at waddr = ENTRIES-1.
  - out_count changes by +1 on a write fire alone and by -1 on a read fire alone. It is unchanged when both fire in the same cycle.
  - When full, writes stall even if a read fires in the same cycle, because out_wr_ready is registered from state.
  - When empty, a same-cycle write does not satisfy a read. The read is dropped.
- Random-access mode (in_mode = 1):
  - out_wr_ready is 1.
  - A write goes to mem[in_addr]. A read of mem[in_addr] returns next cycle with out_rd_valid.
  - Pointers, count and flags hold their values.
  - in_addr ≥ ENTRIES is ignored: no write, and a read returns 0 with out_rd_valid = 1.
- Read-during-write to the same address returns the old data. This holds in both modes.
- in_clr:
  - Sets waddr, raddr and count to 0.
  - Has priority over any read or write in the same cycle. Those requests are dropped.
  - out_rd_valid is 0 in the next cycle.
- in_mode changes only when no request is asserted. Pointers persist across mode changes.
- Async reset mid-operation immediately forces all outputs to their reset values. Any in-flight read is lost.

## Timing
- Write latency: data is readable on the cycle after the write fire.
- Read latency: exactly 1 cycle from the read fire to out_rd_valid with out_rdata. out_rdata holds its value when out_rd_valid is 0.
- out_count, out_full, out_empty and out_wr_ready are registered. They update on the edge after a fire.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- PROJ_FM_RAM_PARITY_EN defined:
  - Each entry stores DATA_BITS+1 bits, with an even-parity bit computed on write.
  - A read recomputes parity. out_parity_err asserts with out_rd_valid when it mismatches.
  - out_rdata is still returned unmodified.
- PROJ_FM_RAM_PARITY_EN undefined:
  - No parity storage.
  - out_parity_err is tied to 0.

## Test plan
- Reset, then 8 stream writes of 0x00..0x07 with in_rd_req = 0 -> out_count steps to 8, out_full = 1, out_wr_ready = 0, out_wrap pulses once after the 8th write.
- From full, 8 back-to-back reads -> out_rd_valid each cycle with data 0x00..0x07 one cycle after each request, then out_empty = 1. A 9th request gives no out_rd_valid.
- Write and read together with count = 3 over 20 cycles -> count stays 3, data stays in FIFO order, and both pointers wrap cleanly past index 7.
- Random mode: write 0xA5 to addr 5, then read addr 5 while writing 0x3C to addr 5 -> 0xA5 returned, next read returns 0x3C, out_count unchanged.
- in_clr asserted with in_wr_valid and in_rd_req at count = 4 -> count 0, out_empty = 1, no write, out_rd_valid = 0. Async reset mid-burst -> all outputs at reset values immediately.
- With PROJ_FM_RAM_PARITY_EN, force-flip one stored bit of addr 2 -> read of addr 2 gives out_parity_err = 1. A clean read of addr 3 gives 0.

Source files
------------

// File: rtl/proj_fm_stream_ram_if.sv
// Bus bundle for proj_fm_stream_ram: stream/random-access controls, write handshake, read return and status.
// Instantiate with the same ENTRIES/DATA_BITS as the RAM it connects to.
interface proj_fm_stream_ram_if #(
    parameter int ENTRIES   = 8,
    parameter int DATA_BITS = 8
);
    localparam int ADDR_BITS = $clog2(ENTRIES);
    localparam int CNT_BITS  = $clog2(ENTRIES + 1);

    logic                 in_mode;
    logic                 in_clr;
    logic                 in_wr_valid;
    logic                 out_wr_ready;
    logic [DATA_BITS-1:0] in_wdata;
    logic [ADDR_BITS-1:0] in_addr;
    logic                 in_rd_req;
    logic                 out_rd_valid;
    logic [DATA_BITS-1:0] out_rdata;
    logic [CNT_BITS-1:0]  out_count;
    logic                 out_full;
    logic                 out_empty;
    logic                 out_wrap;
    logic                 out_parity_err;

    modport master (
        output in_mode, in_clr, in_wr_valid, in_wdata, in_addr, in_rd_req,
        input  out_wr_ready, out_rd_valid, out_rdata, out_count, out_full,
               out_empty, out_wrap, out_parity_err
    );

    modport slave (
        input  in_mode, in_clr, in_wr_valid, in_wdata, in_addr, in_rd_req,
        output out_wr_ready, out_rd_valid, out_rdata, out_count, out_full,
               out_empty, out_wrap, out_parity_err
    );
endinterface

// File: rtl/proj_fm_stream_ram.sv
// Feature-map slice RAM with auto-incrementing stream pointers and a random-access debug/preload mode.
// Define PROJ_FM_RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module proj_fm_stream_ram #(
    parameter int ENTRIES   = 8,
    parameter int DATA_BITS = 8
) (
    input logic                 in_clk,
    input logic                 in_rst_n,
    proj_fm_stream_ram_if.slave bus
);
    localparam int ADDR_BITS = $clog2(ENTRIES);
    localparam int CNT_BITS  = $clog2(ENTRIES + 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR   = ADDR_BITS'(ENTRIES - 1);
    localparam logic [ADDR_BITS:0]   ENTRIES_EXT = (ADDR_BITS + 1)'(ENTRIES);
    localparam logic [CNT_BITS-1:0]  FULL_COUNT  = CNT_BITS'(ENTRIES);
`ifdef PROJ_FM_RAM_PARITY_EN
    localparam int MEM_BITS = DATA_BITS + 1;
`else
    localparam int MEM_BITS = DATA_BITS;
`endif

    logic [MEM_BITS-1:0]  mem [ENTRIES];
    logic [MEM_BITS-1:0]  wr_word;
    logic [MEM_BITS-1:0]  rd_word;
    logic [ADDR_BITS-1:0] waddr, raddr, waddr_next, raddr_next;
    logic [ADDR_BITS-1:0] wr_addr, rd_addr;
    logic [CNT_BITS-1:0]  count, count_next;
    logic                 full_q, empty_q;
    logic                 addr_ok, rd_ok;
    logic                 stream_wr, stream_rd, wr_fire, rd_fire;
    logic                 rd_valid_q, wrap_q;
    logic [DATA_BITS-1:0] rdata_q;

`ifdef PROJ_FM_RAM_PARITY_EN
    assign wr_word = {^bus.in_wdata, bus.in_wdata};
`else
    assign wr_word = bus.in_wdata;
`endif

    // Flags come from registered state, so a full RAM stalls writes even when a read drains it this cycle.
    always_comb begin
        addr_ok    = ({1'b0, bus.in_addr} < ENTRIES_EXT);
        rd_ok      = !bus.in_mode || addr_ok;
        stream_wr  = !bus.in_mode && bus.in_wr_valid && !full_q && !bus.in_clr;
        stream_rd  = !bus.in_mode && bus.in_rd_req && !empty_q && !bus.in_clr;
        wr_fire    = stream_wr || (bus.in_mode && bus.in_wr_valid && addr_ok && !bus.in_clr);
        rd_fire    = stream_rd || (bus.in_mode && bus.in_rd_req && !bus.in_clr);
        wr_addr    = bus.in_mode ? bus.in_addr : waddr;
        rd_addr    = bus.in_mode ? bus.in_addr : raddr;
        waddr_next = waddr;
        raddr_next = raddr;
        count_next = count;
        if (stream_wr) begin
            waddr_next = (waddr == LAST_ADDR) ? '0 : waddr + ADDR_BITS'(1);
        end
        if (stream_rd) begin
            raddr_next = (raddr == LAST_ADDR) ? '0 : raddr + ADDR_BITS'(1);
        end
        case ({stream_wr, stream_rd})
            2'b10:   count_next = count + CNT_BITS'(1);
            2'b01:   count_next = count - CNT_BITS'(1);
            default: count_next = count;
        endcase
        if (bus.in_clr) begin
            waddr_next = '0;
            raddr_next = '0;
            count_next = '0;
        end
    end

    assign rd_word = mem[rd_addr];

    always_ff @(posedge in_clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            waddr      <= '0;
            raddr      <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            rdata_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            waddr      <= waddr_next;
            raddr      <= raddr_next;
            count      <= count_next;
            full_q     <= (count_next == FULL_COUNT);
            empty_q    <= (count_next == '0);
            rd_valid_q <= rd_fire;
            wrap_q     <= stream_wr && (waddr == LAST_ADDR);
            if (rd_fire) begin
                rdata_q <= rd_ok ? rd_word[DATA_BITS-1:0] : '0;
            end
        end
    end

`ifdef PROJ_FM_RAM_PARITY_EN
    logic perr_q;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= rd_fire && rd_ok && (^rd_word);
        end
    end

    assign bus.out_parity_err = perr_q;
`else
    assign bus.out_parity_err = 1'b0;
`endif

    assign bus.out_wr_ready = bus.in_mode || !full_q;
    assign bus.out_rd_valid = rd_valid_q;
    assign bus.out_rdata    = rdata_q;
    assign bus.out_count    = count;
    assign bus.out_full     = full_q;
    assign bus.out_empty    = empty_q;
    assign bus.out_wrap     = wrap_q;
endmodule
